// File: rtl/iiitb_sd_serializer_if.sv
// Word-in / serial-out bus of the sequence-detector serializer.
interface iiitb_sd_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             dout;
    logic             dout_valid;
    logic             busy;
    logic             frame_done;

    // Word source / serial consumer side
    modport master (
        output in_data, in_valid,
        input  in_ready, dout, dout_valid, busy, frame_done
    );

    // Serializer side
    modport slave (
        input  in_data, in_valid,
        output in_ready, dout, dout_valid, busy, frame_done
    );
endinterface

// File: rtl/iiitb_sd_serializer.sv
// Parallel-to-serial front end: one shifting word plus one holding word, so
// back-to-back frames stream without an idle cycle between them.
module iiitb_sd_serializer #(
    parameter int   WIDTH     = 8,
    parameter int   DIV       = 1,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    iiitb_sd_serializer_if.slave bus
);
    localparam int BW = $clog2(WIDTH);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]    div_cnt_q, div_cnt_d;
    logic             dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;

    logic             in_ready, xfer, last_clk, free;
    logic             load_hold, load_in, load;
    logic [WIDTH-1:0] load_word;

    // Handshake and shifter-load decisions; the held word always wins over
    // a fresh input so word order is preserved.
    assign in_ready  = !hold_full_q;
    assign xfer      = bus.in_valid & in_ready;
    assign last_clk  = (state_q == SHIFT) && (bit_cnt_q == BIT_LAST) && (div_cnt_q == DIV_LAST);
    assign free      = (state_q == IDLE) || last_clk;
    assign load_hold = free & hold_full_q;
    assign load_in   = free & !hold_full_q & xfer;
    assign load      = load_hold | load_in;
    assign load_word = load_hold ? hold_q : bus.in_data;

    // State register and datapath flops; reset drops any frame and held word
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sh_q         <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            bit_cnt_q    <= '0;
            div_cnt_q    <= '0;
            dout_q       <= IDLE_BIT;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sh_q         <= sh_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            bit_cnt_q    <= bit_cnt_d;
            div_cnt_q    <= div_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next state: start on any load, fall back to IDLE when a frame ends dry
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = SHIFT;
            SHIFT:   if (last_clk && !load) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shifter, counters and holding register
    always_comb begin
        sh_d        = sh_q;
        bit_cnt_d   = bit_cnt_q;
        div_cnt_d   = div_cnt_q;
        hold_d      = hold_q;
        hold_full_d = (hold_full_q & !load_hold) | (xfer & !load_in);
        if (xfer && !load_in) hold_d = bus.in_data;
        if (load) begin
            sh_d      = load_word;
            bit_cnt_d = '0;
            div_cnt_d = '0;
        end else if (last_clk) begin
            bit_cnt_d = '0;
            div_cnt_d = '0;
        end else if (state_q == SHIFT) begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
                bit_cnt_d = bit_cnt_q + BW'(1);
                sh_d      = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
            end else begin
                div_cnt_d = div_cnt_q + DW'(1);
            end
        end
    end

    // Registered outputs are computed from next-state so they line up with
    // the bit that the shifter presents in the following cycle.
    always_comb begin
        dout_valid_d = (state_d == SHIFT);
        dout_d       = IDLE_BIT;
        if (dout_valid_d) dout_d = MSB_FIRST ? sh_d[WIDTH-1] : sh_d[0];
        frame_done_d = dout_valid_d && (bit_cnt_d == BIT_LAST) && (div_cnt_d == DIV_LAST);
        busy_d       = dout_valid_d | hold_full_d;
    end

    assign bus.in_ready   = in_ready;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_iiitb_sd_serializer.sv
// Directed bench: one DIV=1 serializer for most scenarios, one DIV=3 for hold timing.
module tb_iiitb_sd_serializer;
    logic clk = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    iiitb_sd_serializer_if #(.WIDTH(8)) b1 ();
    iiitb_sd_serializer_if #(.WIDTH(8)) b3 ();

    iiitb_sd_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0))
        u_d1 (.clk(clk), .reset(reset), .bus(b1.slave));
    iiitb_sd_serializer #(.WIDTH(8), .DIV(3), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0))
        u_d3 (.clk(clk), .reset(reset), .bus(b3.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] pat;
        logic [7:0]  w [3];
        logic [23:0] cap;
        int          idx, nbits, nfd, gap, seen, fd_ready, fd_idx, nv;
        logic        xf;

        reset = 1'b1;
        b1.in_valid = 1'b0; b1.in_data = '0;
        b3.in_valid = 1'b0; b3.in_data = '0;

        // 1: reset state
        tick(); tick();
        chk("rst_dout",  b1.dout, 0);
        chk("rst_dv",    b1.dout_valid, 0);
        chk("rst_busy",  b1.busy, 0);
        chk("rst_fd",    b1.frame_done, 0);
        chk("rst_ready", b1.in_ready, 1);
        reset = 1'b0;
        tick();

        // 2: single frame A5
        pat = 16'h00A5;
        b1.in_data = 8'hA5; b1.in_valid = 1'b1;
        tick();
        b1.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("a5_bit", b1.dout, pat[7-i]);
            chk("a5_dv",  b1.dout_valid, 1);
            chk("a5_fd",  b1.frame_done, (i == 7));
            tick();
        end
        chk("a5_end_dv",   b1.dout_valid, 0);
        chk("a5_end_dout", b1.dout, 0);
        chk("a5_end_busy", b1.busy, 0);

        // 3: gapless A5 then 0F
        pat = 16'hA50F;
        b1.in_data = 8'hA5; b1.in_valid = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            chk("gl_bit", b1.dout, pat[15-i]);
            chk("gl_dv",  b1.dout_valid, 1);
            chk("gl_fd",  b1.frame_done, (i == 7 || i == 15));
            if (i == 1) chk("gl_ready_held", b1.in_ready, 0);
            if (i == 0) begin b1.in_data = 8'h0F; b1.in_valid = 1'b1; end
            else b1.in_valid = 1'b0;
            tick();
        end
        chk("gl_end_dv", b1.dout_valid, 0);

        // 4: DIV=3, A0 -> each bit held 3 clocks
        pat = 16'h00A0;
        b3.in_data = 8'hA0; b3.in_valid = 1'b1;
        tick();
        b3.in_valid = 1'b0;
        for (int i = 0; i < 24; i++) begin
            chk("d3_bit", b3.dout, pat[7 - i/3]);
            chk("d3_dv",  b3.dout_valid, 1);
            chk("d3_fd",  b3.frame_done, (i == 23));
            tick();
        end
        chk("d3_end_dv", b3.dout_valid, 0);

        // 5: three words with in_valid held high
        w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33;
        idx = 0; nbits = 0; nfd = 0; gap = 0; seen = 0; fd_ready = -1; fd_idx = -1;
        cap = '0;
        for (int c = 0; c < 40; c++) begin
            if (b1.dout_valid) begin
                cap = {cap[22:0], b1.dout};
                nbits++;
                if (seen == 2) gap = 1;
                seen = 1;
            end else if (seen == 1) seen = 2;
            if (b1.frame_done) begin
                if (nfd == 0) begin fd_ready = b1.in_ready; fd_idx = idx; end
                nfd++;
            end
            if (idx < 3) begin b1.in_valid = 1'b1; b1.in_data = w[idx]; end
            else b1.in_valid = 1'b0;
            xf = b1.in_valid & b1.in_ready;
            tick();
            if (xf) idx++;
        end
        chk("st_words_acc", idx, 3);
        chk("st_nbits",     nbits, 24);
        chk("st_stream",    cap, 24'h112233);
        chk("st_nfd",       nfd, 3);
        chk("st_gap",       gap, 0);
        chk("st_stall_rdy", fd_ready, 0);
        chk("st_stall_idx", fd_idx, 2);

        // 6: reset mid-frame with a held word
        b1.in_data = 8'hFF; b1.in_valid = 1'b1;
        tick();
        b1.in_data = 8'h55; b1.in_valid = 1'b1;
        tick();
        b1.in_valid = 1'b0;
        chk("mr_held", b1.in_ready, 0);
        tick(); tick(); tick();
        chk("mr_bit4_dv", b1.dout_valid, 1);
        reset = 1'b1;
        tick();
        chk("mr_dout",  b1.dout, 0);
        chk("mr_dv",    b1.dout_valid, 0);
        chk("mr_busy",  b1.busy, 0);
        chk("mr_fd",    b1.frame_done, 0);
        reset = 1'b0;
        nv = 0; nfd = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (b1.dout_valid) nv++;
            if (b1.frame_done) nfd++;
        end
        chk("mr_no_emit", nv, 0);
        chk("mr_no_fd",   nfd, 0);
        chk("mr_ready",   b1.in_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
